// File: rtl/ea_sequencer_if.sv
// Handshake and control bundle between the effective-address sequencer and its datapath/memory.
// The master modport is the sequencer; the slave modport is the surrounding datapath.
interface ea_sequencer_if;
    logic       start;
    logic [1:0] mode;
    logic       mem_ready;
    logic [7:0] data_in;

    logic       busy;
    logic       done;
    logic       mem_rd;
    logic       addr_sel;
    logic       pc_inc;
    logic       ea_oe;
    logic       ea_wr;
    logic       ea_lhb;
    logic       ea_inc;
    logic       ea_add_idx;
    logic       idx_oe;
    logic       zero_oe;
    logic       tmp_oe;
    logic [7:0] tmp_data;

    modport master (
        input  start, mode, mem_ready, data_in,
        output busy, done, mem_rd, addr_sel, pc_inc, ea_oe, ea_wr, ea_lhb, ea_inc,
               ea_add_idx, idx_oe, zero_oe, tmp_oe, tmp_data
    );

    modport slave (
        output start, mode, mem_ready, data_in,
        input  busy, done, mem_rd, addr_sel, pc_inc, ea_oe, ea_wr, ea_lhb, ea_inc,
               ea_add_idx, idx_oe, zero_oe, tmp_oe, tmp_data
    );
endinterface

// File: rtl/ea_sequencer.sv
// Effective-address sequencer: walks ABS, ABS_IDX, ZP and IND addressing modes by strobing
// an external EA register, PC and bus drivers; only the IND low byte is held locally in tmp.
module ea_sequencer (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    ea_sequencer_if.master        bus
);

    typedef enum logic [3:0] {
        StIdle,
        StFetchLo,
        StFetchHi,
        StZpHi,
        StAddIdx,
        StIndLo,
        StIndInc,
        StIndHi,
        StIndWrLo,
        StDone
    } state_e;

    localparam logic [1:0] ModeAbs    = 2'b00;
    localparam logic [1:0] ModeAbsIdx = 2'b01;
    localparam logic [1:0] ModeZp     = 2'b10;
    localparam logic [1:0] ModeInd    = 2'b11;

    state_e     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] tmp_q, tmp_d;
    logic       fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mode_q  <= ModeAbs;
            tmp_q   <= 8'h00;
        end else if (clk_en) begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tmp_q   <= tmp_d;
        end
    end

    // A read state completes only when the edge is enabled and memory has the data.
    assign fire = clk_en & bus.mem_ready;

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        tmp_d          = tmp_q;
        bus.busy       = (state_q != StIdle);
        bus.done       = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.addr_sel   = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.ea_oe      = 1'b0;
        bus.ea_wr      = 1'b0;
        bus.ea_lhb     = 1'b0;
        bus.ea_inc     = 1'b0;
        bus.ea_add_idx = 1'b0;
        bus.idx_oe     = 1'b0;
        bus.zero_oe    = 1'b0;
        bus.tmp_oe     = 1'b0;
        bus.tmp_data   = tmp_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    state_d = StFetchLo;
                end
            end
            StFetchLo: begin
                bus.mem_rd = 1'b1;
                if (fire) begin
                    bus.ea_wr  = 1'b1;
                    bus.pc_inc = 1'b1;
                    state_d    = (mode_q == ModeZp) ? StZpHi : StFetchHi;
                end
            end
            StFetchHi: begin
                bus.mem_rd = 1'b1;
                bus.ea_lhb = 1'b1;
                if (fire) begin
                    bus.ea_wr  = 1'b1;
                    bus.pc_inc = 1'b1;
                    unique case (mode_q)
                        ModeAbsIdx: state_d = StAddIdx;
                        ModeInd:    state_d = StIndLo;
                        default:    state_d = StDone;
                    endcase
                end
            end
            StZpHi: begin
                bus.zero_oe = 1'b1;
                bus.ea_lhb  = 1'b1;
                bus.ea_wr   = clk_en;
                state_d     = StDone;
            end
            StAddIdx: begin
                bus.idx_oe     = 1'b1;
                bus.ea_add_idx = clk_en;
                state_d        = StDone;
            end
            StIndLo: begin
                bus.mem_rd   = 1'b1;
                bus.addr_sel = 1'b1;
                if (fire) begin
                    tmp_d   = bus.data_in;
                    state_d = StIndInc;
                end
            end
            StIndInc: begin
                bus.ea_inc = clk_en;
                state_d    = StIndHi;
            end
            StIndHi: begin
                bus.mem_rd   = 1'b1;
                bus.addr_sel = 1'b1;
                bus.ea_lhb   = 1'b1;
                if (fire) begin
                    bus.ea_wr = 1'b1;
                    state_d   = StIndWrLo;
                end
            end
            StIndWrLo: begin
                bus.tmp_oe = 1'b1;
                bus.ea_wr  = clk_en;
                state_d    = StDone;
            end
            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/ea_sequencer.md
EA_SEQUENCER -- requirements
Module: ea_sequencer

Interface
REQ-001 SHALL have these ports: clk, in, 1, system clock, all state changes on its rising edge.
REQ-002 SHALL have rst_n, in, 1, asynchronous active-low reset.
REQ-003 SHALL have clk_en, in, 1, clock enable; state and registers advance only when it is 1.
REQ-004 SHALL have start, in, 1, request to begin an address sequence, sampled only in IDLE.
REQ-005 SHALL have mode, in, 2, addressing mode latched on start: 00 ABS, 01 ABS_IDX, 10 ZP, 11 IND.
REQ-006 SHALL have mem_ready, in, 1, memory read-data-valid handshake.
REQ-007 SHALL have data_in, in, 8, system data bus value, for the IND temporary capture.
REQ-008 SHALL have busy, out, 1, high in every state except IDLE.
REQ-009 SHALL have done, out, 1, one-cycle pulse when the EA holds the final address.
REQ-010 SHALL have mem_rd, out, 1, memory read request.
REQ-011 SHALL have addr_sel, out, 1, memory address source: 0 = PC, 1 = EA.
REQ-012 SHALL have pc_inc, out, 1, PC increment strobe.
REQ-013 SHALL have ea_oe, ea_wr, ea_lhb, ea_inc and ea_add_idx, out, 1 each, EA register controls.
REQ-014 SHALL have idx_oe, zero_oe and tmp_oe, out, 1 each, bus drive enables for the index register, a constant 8'h00, and the internal tmp.
REQ-015 SHALL have tmp_data, out, 8, internal temporary byte, driven to the bus when tmp_oe is 1.

Function
REQ-016 SHALL implement the states IDLE, FETCH_LO, FETCH_HI, ZP_HI, ADD_IDX, IND_LO, IND_INC, IND_HI, IND_WRLO and DONE, with one-hot or binary encoding free.
REQ-017 In IDLE with clk_en=1 and start=1, it SHALL latch mode and go to FETCH_LO; start while busy SHALL be ignored.
REQ-018 The read states are FETCH_LO, FETCH_HI, IND_LO and IND_HI; they SHALL hold mem_rd=1 and stay put until mem_ready=1.
REQ-019 A read state SHALL complete on the edge where clk_en=1 and mem_ready=1.
REQ-020 addr_sel SHALL be 0 in FETCH_LO and FETCH_HI, and 1 in IND_LO and IND_HI.
REQ-021 FETCH_LO completion: it SHALL assert ea_wr with ea_lhb=0 and pc_inc; it SHALL go to ZP_HI if mode=ZP, otherwise to FETCH_HI.
REQ-022 FETCH_HI completion: it SHALL assert ea_wr with ea_lhb=1 and pc_inc; the next state SHALL be ABS→DONE, ABS_IDX→ADD_IDX, IND→IND_LO.
REQ-023 ZP_HI SHALL be a single cycle with zero_oe, ea_wr and ea_lhb=1, then go to DONE.
REQ-024 ADD_IDX SHALL be a single cycle with idx_oe and ea_add_idx, then go to DONE; EA addition wraps modulo 2^16, and no carry flag is reported.
REQ-025 IND_LO completion: it SHALL capture data_in into tmp and go to IND_INC, with ea_wr=0.
REQ-026 IND_INC SHALL be a single cycle with ea_inc, then go to IND_HI; the increment wraps 16'hFFFF→16'h0000.
REQ-027 IND_HI completion: it SHALL assert ea_wr with ea_lhb=1, then go to IND_WRLO.
REQ-028 IND_WRLO SHALL be a single cycle with tmp_oe, ea_wr and ea_lhb=0, then go to DONE.
REQ-029 DONE SHALL assert done for one cycle, then go to IDLE; start is not accepted in DONE.
REQ-030 Strobes (ea_wr, ea_inc, ea_add_idx, pc_inc) SHALL be combinational from state, mem_ready and clk_en, and SHALL be 0 whenever clk_en=0.
REQ-031 ea_wr, ea_inc and ea_add_idx SHALL be mutually exclusive in every cycle.
REQ-032 ea_oe SHALL be 0 at all times, since this block never reads EA onto the bus.
REQ-033 At most one of idx_oe, zero_oe, tmp_oe and ea_oe SHALL be 1 in any cycle; all are 0 in IDLE and DONE.
REQ-034 With clk_en=0 the block SHALL hold state and tmp, and clk_en low mid-handshake SHALL not lose a pending mem_ready.
REQ-035 Latencies at clk_en=1 and mem_ready=1 from the start edge to done high SHALL be: ABS 3, ZP 3, ABS_IDX 4, IND 7 cycles.

Reset
REQ-036 rst_n=0 SHALL asynchronously force IDLE and tmp=8'h00, and drive all outputs to 0.
REQ-037 Reset asserted mid-sequence SHALL abort with no further strobes; after release the block sits in IDLE until a new start.

Verification
REQ-038 ABS: start with mode=00 and memory bytes 34,12, mem_ready always 1 → ea_wr lo then hi, pc_inc ×2, EA=16'h1234, done on cycle 3.
REQ-039 ABS_IDX: bytes FF,12 with index 8'h05 → ea_add_idx one cycle, EA=16'h1304, done on cycle 4.
REQ-040 ZP: byte 80 → zero_oe cycle, EA=16'h0080, pc_inc once, done on cycle 3.
REQ-041 IND with pointer 16'h20FF holding [20FF]=CD and [2100]=AB → EA=16'hABCD, with tmp_oe active in exactly one cycle.
REQ-042 mem_ready held low 3 cycles in FETCH_HI, plus clk_en low 2 cycles → mem_rd held, no strobes, latency extended by exactly 5 cycles.
REQ-043 rst_n pulsed low in IND_INC → all outputs 0 immediately, busy=0, and a new ABS sequence then completes normally.
